// File: rtl/ctrl_sequencer.sv
// Multi-cycle control unit: latches one instruction per start pulse and walks
// T1..T3, driving register-file load enables, bus source select and ALU strobes.
module ctrl_sequencer #(
    parameter int NREG  = 4,
    parameter int SEL_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [7:0]       instr,
    output logic [NREG-1:0]  r_en,
    output logic [SEL_W-1:0] bus_sel,
    output logic             a_load,
    output logic             g_load,
    output logic             alu_sub,
    output logic             busy,
    output logic             done
);

    // state | meaning
    // IDLE  | waiting for start; IR captured on start
    // T1    | MV/MVI: write rx and finish; ADD/SUB: load A from rx
    // T2    | ADD/SUB: put ry on bus, load G with A +/- bus
    // T3    | ADD/SUB: write G back into rx and finish
    typedef enum logic [1:0] {IDLE, T1, T2, T3} state_t;

    localparam logic [1:0]       OP_MV   = 2'b00;
    localparam logic [SEL_W-1:0] SEL_DIN = SEL_W'(4);
    localparam logic [SEL_W-1:0] SEL_G   = SEL_W'(5);

    state_t          state, state_nxt;
    logic [7:0]      ir;
    logic [1:0]      op, rx, ry;
    logic [NREG-1:0] rx_onehot;
    logic            ir_unused;

    assign op        = ir[7:6];
    assign rx        = ir[5:4];
    assign ry        = ir[3:2];
    assign rx_onehot = NREG'(1) << rx;
    assign ir_unused = ^ir[1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            ir    <= 8'h00;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start)
                ir <= instr;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    state_nxt = start ? T1 : IDLE;
            T1:      state_nxt = op[1] ? T2 : IDLE;
            T2:      state_nxt = T3;
            T3:      state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        r_en    = '0;
        bus_sel = '0;
        a_load  = 1'b0;
        g_load  = 1'b0;
        alu_sub = 1'b0;
        busy    = (state != IDLE);
        done    = 1'b0;
        case (state)
            T1: begin
                if (op[1]) begin
                    bus_sel = SEL_W'(rx);
                    a_load  = 1'b1;
                end else begin
                    bus_sel = (op == OP_MV) ? SEL_W'(ry) : SEL_DIN;
                    r_en    = rx_onehot;
                    done    = 1'b1;
                end
            end
            T2: begin
                bus_sel = SEL_W'(ry);
                g_load  = 1'b1;
                alu_sub = op[0];
            end
            T3: begin
                bus_sel = SEL_G;
                r_en    = rx_onehot;
                done    = 1'b1;
            end
            default: ;
        endcase
    end

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Multi-cycle control unit of the simple processor, directly upstream of the 8-bit register file.
- Accepts one 8-bit instruction per start pulse and steps through up to three execute states.
- Drives per-register load enables, the shared-bus source select, and the accumulator (A) and result (G) load strobes.
- Owns no datapath storage except its instruction register (IR).

Parameters:
- NREG, 4: number of general registers R0..R3. Only 4 is supported; the instruction field encoding fixes it.
- SEL_W, 3: width of bus_sel.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  synchronous reset, active-high
- start  in  1  instruction valid; sampled only in IDLE
- instr  in  8  instruction: [7:6] op, [5:4] rx, [3:2] ry, [1:0] ignored
- r_en  out  NREG  one-hot register load enables; bit i loads Ri from the bus at the next edge
- bus_sel  out  SEL_W  bus source: 0..3 = R0..R3, 4 = DIN, 5 = G; others unused
- a_load  out  1  load A from the bus
- g_load  out  1  load G with the ALU result
- alu_sub  out  1  ALU operation: 1 = A − bus, 0 = A + bus
- busy  out  1  high in any state other than IDLE
- done  out  1  single-cycle pulse in the final execute state

Behaviour:
- State register and IR update on the rising clk edge. All outputs decode combinationally from the state and IR only (Moore); instr and start never reach the outputs combinationally.
- Reset (rst=1 at an edge):
  - state = IDLE, IR = 8'h00.
  - In the following cycle: r_en=0, bus_sel=0, a_load=g_load=alu_sub=busy=done=0.
  - Reset overrides start and any in-flight instruction.
  - A reset mid-instruction aborts it; no further r_en or g_load is issued.
- Opcodes: 00 MV (rx←ry), 01 MVI (rx←DIN), 10 ADD (rx←rx+ry), 11 SUB (rx←rx−ry).
- IDLE:
  - All outputs 0.
  - If start=1: IR←instr, go to T1. Otherwise stay in IDLE.
- T1:
  - MV: bus_sel=ry, r_en[rx]=1, done=1 → IDLE.
  - MVI: bus_sel=4, r_en[rx]=1, done=1 → IDLE.
  - ADD/SUB: bus_sel=rx, a_load=1 → T2.
- T2 (ADD/SUB only): bus_sel=ry, g_load=1, alu_sub=IR[6] → T3.
- T3: bus_sel=5, r_en[rx]=1, done=1 → IDLE.
- Latency, counted from the edge that samples start:
  - MV/MVI: done in the next cycle; 2 cycles total including IDLE.
  - ADD/SUB: done 3 cycles after acceptance.
- Back-to-back instructions: start held high during the done cycle is ignored. The next instruction is accepted at the first edge where state=IDLE, giving a throughput of one instruction per 2 (MV/MVI) or 4 (ADD/SUB) cycles.
- start pulses while busy=1 are dropped, not queued. IR is stable for the whole instruction.
- rx=ry is legal. ADD R1,R1 doubles R1, with the sequence unchanged.
- Invariants: r_en is at most one-hot in every cycle. r_en, a_load and g_load are never asserted in the same cycle.
- instr[1:0] have no effect.
- No arithmetic is done in this block. Overflow and wrap are the ALU's concern.

Test Plan:
- Reset: hold rst for 2 cycles with start=1, instr=8'h40 → in the cycle after rst drops, all outputs 0, busy=0, IR=00.
- MV R2←R1: instr=8'h24 (op00 rx=2 ry=1), start pulse → next cycle r_en=4'b0100, bus_sel=1, done=1; following cycle busy=0.
- MVI R3←DIN: instr=8'h70 → next cycle r_en=4'b1000, bus_sel=4, done=1.
- SUB R0←R0−R3: instr=8'hCC → T1 bus_sel=0, a_load=1; T2 bus_sel=3, g_load=1, alu_sub=1; T3 bus_sel=5, r_en=4'b0001, done=1.
- Dropped start: issue ADD 8'h94, then pulse start with instr=8'h24 during T2 → the second instruction is ignored; after done, IDLE persists and no r_en fires.
- Reset mid-op: ADD 8'h94, assert rst in T2 → next cycle state IDLE, r_en=0, done never pulses.
